// File: rtl/apb_rr_arbiter_pkg.sv
// Shared APB arbitration types: address/data words, arbiter FSM states, error read data.
package apb_rr_arbiter_pkg;

    typedef logic [31:0] apb_addr_t;
    typedef logic [31:0] apb_data_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } arb_state_e;

    // Same pattern the register blocks return on a decode error
    localparam apb_data_t APB_ERR_DATA = 32'hBADD_C0DE;

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr_i, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; gnt_vld_o is low when no request is pending.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 gnt_vld_o
);

    localparam int W = $clog2(N);

    logic [N-1:0] rot;
    logic [W:0]   sum;

    always_comb begin
        rot       = N'({req_i, req_i} >> ptr_i);
        sum       = '0;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        // Descending scan so the lowest rotated position is the one left standing
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_vld_o = 1'b1;
                sum       = {1'b0, ptr_i} + (W + 1)'(i);
                if (sum >= (W + 1)'(N)) begin
                    sum = sum - (W + 1)'(N);
                end
                gnt_idx_o = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin sharing of one APB target among NUM_REQ APB masters, with a hung-transfer watchdog.
// Latency: req psel cycle 0 -> m_psel cycle 1 -> m_penable cycle 2; req_pready same cycle as m_pready.
// Backpressure: losers and waiting requesters see req_pready=0 and hold their transfer until served.
module apb_rr_arbiter
    import apb_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_psel,
    input  logic [NUM_REQ-1:0]      req_penable,
    input  logic [NUM_REQ-1:0]      req_pwrite,
    input  apb_addr_t [NUM_REQ-1:0] req_paddr,
    input  apb_data_t [NUM_REQ-1:0] req_pwdata,
    output apb_data_t               req_prdata,
    output logic [NUM_REQ-1:0]      req_pready,
    output logic [NUM_REQ-1:0]      req_pslverr,
    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output apb_addr_t               m_paddr,
    output apb_data_t               m_pwdata,
    input  apb_data_t               m_prdata,
    input  logic                    m_pready,
    input  logic                    m_pslverr
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] gnt_q, gnt_d;
    logic             pwrite_q, pwrite_d;
    apb_addr_t        paddr_q, paddr_d;
    apb_data_t        pwdata_q, pwdata_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               timeout_hit;

    // The phase is tracked internally, so requester penable carries no information here
    logic unused_penable;
    assign unused_penable = ^req_penable;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i     (req_psel),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (pick_idx),
        .gnt_vld_o (pick_vld)
    );

    assign gnt_onehot  = NUM_REQ'(1) << gnt_q;
    assign timeout_hit = (TIMEOUT_CYC > 0) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        timer_d     = timer_q;
        m_psel      = 1'b0;
        m_penable   = 1'b0;
        m_pwrite    = 1'b0;
        m_paddr     = '0;
        m_pwdata    = '0;
        req_pready  = '0;
        req_pslverr = '0;
        req_prdata  = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_d    = pick_idx;
                    pwrite_d = req_pwrite[pick_idx];
                    paddr_d  = req_paddr[pick_idx];
                    pwdata_d = req_pwdata[pick_idx];
                    rr_ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                    state_d  = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                m_psel   = 1'b1;
                m_pwrite = pwrite_q;
                m_paddr  = paddr_q;
                m_pwdata = pwdata_q;
                timer_d  = '0;
                state_d  = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
                m_pwrite  = pwrite_q;
                m_paddr   = paddr_q;
                m_pwdata  = pwdata_q;
                if (m_pready) begin
                    req_pready  = gnt_onehot;
                    req_pslverr = m_pslverr ? gnt_onehot : '0;
                    req_prdata  = m_prdata;
                    state_d     = ARB_IDLE;
                end else if (timeout_hit) begin
                    req_pready  = gnt_onehot;
                    req_pslverr = gnt_onehot;
                    req_prdata  = APB_ERR_DATA;
                    state_d     = ARB_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: two requesters, 64-cycle watchdog, hand-computed expectations.
module tb_apb_rr_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_psel, req_penable, req_pwrite;
    logic [1:0][31:0] req_paddr, req_pwdata;
    logic [31:0]      req_prdata;
    logic [1:0]       req_pready, req_pslverr;
    logic             m_psel, m_penable, m_pwrite;
    logic [31:0]      m_paddr, m_pwdata, m_prdata;
    logic             m_pready, m_pslverr;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cyc = 0;
    int d1, d2;

    apb_rr_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_psel    (req_psel),
        .req_penable (req_penable),
        .req_pwrite  (req_pwrite),
        .req_paddr   (req_paddr),
        .req_pwdata  (req_pwdata),
        .req_prdata  (req_prdata),
        .req_pready  (req_pready),
        .req_pslverr (req_pslverr),
        .m_psel      (m_psel),
        .m_penable   (m_penable),
        .m_pwrite    (m_pwrite),
        .m_paddr     (m_paddr),
        .m_pwdata    (m_pwdata),
        .m_prdata    (m_prdata),
        .m_pready    (m_pready),
        .m_pslverr   (m_pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven; returns at the negedge of the
    // IDLE cycle following completion, so the caller can update psel before the next grant edge.
    task automatic do_xfer(input string tag, input int waits, input logic [31:0] rdata,
                           input logic serr, input logic [1:0] exp_gnt,
                           input logic [31:0] exp_addr, input logic exp_write,
                           input logic [31:0] exp_wdata);
        logic [1:0][31:0] sv_a, sv_d;
        tick;
        sv_a       = req_paddr;
        sv_d       = req_pwdata;
        req_paddr  = ~req_paddr;
        req_pwdata = ~req_pwdata;
        @(negedge clk);
        chk({tag, ".setup_psel"}, m_psel, 1);
        chk({tag, ".setup_pen"}, m_penable, 0);
        chk({tag, ".setup_addr"}, m_paddr, exp_addr);
        chk({tag, ".setup_wr"}, m_pwrite, exp_write);
        chk({tag, ".setup_wdata"}, m_pwdata, exp_wdata);
        chk({tag, ".setup_rdy"}, req_pready, 0);
        tick;
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            chk({tag, ".wait_rdy"}, req_pready, 0);
            chk({tag, ".wait_pen"}, m_penable, 1);
            tick;
        end
        m_pready  = 1'b1;
        m_prdata  = rdata;
        m_pslverr = serr;
        @(negedge clk);
        done_cyc = cyc;
        chk({tag, ".rdy"}, req_pready, exp_gnt);
        chk({tag, ".err"}, req_pslverr, serr ? exp_gnt : 2'b00);
        chk({tag, ".rdata"}, req_prdata, rdata);
        chk({tag, ".acc_addr"}, m_paddr, exp_addr);
        tick;
        m_pready   = 1'b0;
        m_pslverr  = 1'b0;
        m_prdata   = '0;
        req_paddr  = sv_a;
        req_pwdata = sv_d;
        @(negedge clk);
        chk({tag, ".post_rdy"}, req_pready, 0);
        chk({tag, ".post_psel"}, m_psel, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_psel    = '0;
        req_penable = '0;
        req_pwrite  = '0;
        req_paddr   = '0;
        req_pwdata  = '0;
        m_prdata    = '0;
        m_pready    = 1'b0;
        m_pslverr   = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("rst.psel", m_psel, 0);
        chk("rst.pen", m_penable, 0);
        chk("rst.addr", m_paddr, 0);
        chk("rst.rdy", req_pready, 0);
        chk("rst.err", req_pslverr, 0);
        chk("rst.rdata", req_prdata, 0);

        // Single write from req0
        tick;
        rst_n         = 1'b1;
        req_psel      = 2'b01;
        req_pwrite    = 2'b01;
        req_paddr[0]  = 32'h0000_0208;
        req_pwdata[0] = 32'hA5A5_0001;
        do_xfer("t1", 0, 32'h0, 1'b0, 2'b01, 32'h208, 1'b1, 32'hA5A5_0001);

        // Lone req1 granted twice back to back
        req_psel      = 2'b10;
        req_pwrite    = 2'b00;
        req_paddr[1]  = 32'h0000_0010;
        req_pwdata[1] = 32'h0;
        do_xfer("lone1", 0, 32'h0000_0011, 1'b0, 2'b10, 32'h10, 1'b0, 32'h0);
        do_xfer("lone2", 0, 32'h0000_0022, 1'b0, 2'b10, 32'h10, 1'b0, 32'h0);

        // Simultaneous reads, pointer at 0
        req_psel     = 2'b11;
        req_paddr[0] = 32'h0000_0020;
        req_paddr[1] = 32'h0000_0024;
        req_pwdata   = '0;
        do_xfer("t2a", 0, 32'h0000_1111, 1'b0, 2'b01, 32'h20, 1'b0, 32'h0);
        d1 = done_cyc;
        req_psel = 2'b10;
        do_xfer("t2b", 0, 32'h0000_2222, 1'b0, 2'b10, 32'h24, 1'b0, 32'h0);
        d2 = done_cyc;
        chk("t2.gap", d2 - d1, 3);
        req_psel = 2'b11;
        do_xfer("t2c", 0, 32'h0000_3333, 1'b0, 2'b01, 32'h20, 1'b0, 32'h0);
        req_psel = 2'b00;

        // Read with three target wait states
        req_psel     = 2'b10;
        req_paddr[1] = 32'h0000_0104;
        do_xfer("t3", 3, 32'h1234_5678, 1'b0, 2'b10, 32'h104, 1'b0, 32'h0);
        req_psel = 2'b00;

        // Target never ready: watchdog fires on the 64th ACCESS cycle
        req_psel     = 2'b01;
        req_paddr[0] = 32'h0000_0400;
        tick;
        tick;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            chk("t4.wait_rdy", req_pready, 0);
            tick;
        end
        @(negedge clk);
        chk("t4.rdy", req_pready, 2'b01);
        chk("t4.err", req_pslverr, 2'b01);
        chk("t4.rdata", req_prdata, 32'hBADD_C0DE);
        chk("t4.psel_held", m_psel, 1);
        req_psel = 2'b00;
        tick;
        @(negedge clk);
        chk("t4.psel_drop", m_psel, 0);
        chk("t4.post_rdy", req_pready, 0);

        // Target error on 0x300 for req1; req0 then served cleanly
        req_psel     = 2'b11;
        req_paddr[0] = 32'h0000_0100;
        req_paddr[1] = 32'h0000_0300;
        do_xfer("t5a", 0, 32'h0, 1'b1, 2'b10, 32'h300, 1'b0, 32'h0);
        req_psel = 2'b01;
        do_xfer("t5b", 0, 32'h0000_5555, 1'b0, 2'b01, 32'h100, 1'b0, 32'h0);
        req_psel = 2'b00;

        // Requester drops psel after grant: transfer still completes with a pready pulse
        req_psel     = 2'b01;
        req_paddr[0] = 32'h0000_0500;
        tick;
        req_psel = 2'b00;
        tick;
        m_pready = 1'b1;
        m_prdata = 32'hCAFE_0000;
        @(negedge clk);
        chk("t7.rdy", req_pready, 2'b01);
        chk("t7.rdata", req_prdata, 32'hCAFE_0000);
        tick;
        m_pready = 1'b0;
        m_prdata = '0;
        @(negedge clk);
        chk("t7.post_psel", m_psel, 0);

        // Reset during ACCESS, then pointer restarts at 0
        req_psel     = 2'b01;
        req_paddr[0] = 32'h0000_0600;
        tick;
        req_psel = 2'b00;
        tick;
        @(negedge clk);
        chk("t6.in_access", m_penable, 1);
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        chk("t6.psel", m_psel, 0);
        chk("t6.pen", m_penable, 0);
        chk("t6.addr", m_paddr, 0);
        chk("t6.rdy", req_pready, 0);
        chk("t6.rdata", req_prdata, 0);
        tick;
        rst_n        = 1'b1;
        req_psel     = 2'b11;
        req_paddr[0] = 32'h0000_0700;
        req_paddr[1] = 32'h0000_0704;
        do_xfer("t6b", 0, 32'h0000_7777, 1'b0, 2'b01, 32'h700, 1'b0, 32'h0);
        req_psel = 2'b00;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
